// File: rtl/select_next_hop_if.sv
// -----------------------------------------------------------------------------
// select_next_hop_if
//   Bundles the start/done handshake and the single-port word-memory bus used by
//   select_next_hop.
//
//   Signals:
//     start     begin a scan (driven by the controller)
//     done      scan complete, both result words written
//     address   memory word address
//     wr_en     memory write strobe, one cycle per write
//     data_out  memory write data
//     data_in   memory read data, valid the cycle after address is set
//
//   Modports:
//     master    the next-hop selector (drives the memory bus, reports done)
//     slave     memory plus controller side
// -----------------------------------------------------------------------------
interface select_next_hop_if #(
    parameter int unsigned WORD_WIDTH = 16
);
    logic                  start;
    logic                  done;
    logic [WORD_WIDTH-1:0] address;
    logic                  wr_en;
    logic [WORD_WIDTH-1:0] data_out;
    logic [WORD_WIDTH-1:0] data_in;

    modport master (
        input  start,
        input  data_in,
        output done,
        output address,
        output wr_en,
        output data_out
    );

    modport slave (
        output start,
        output data_in,
        input  done,
        input  address,
        input  wr_en,
        input  data_out
    );
endinterface

// File: rtl/select_next_hop.sv
// -----------------------------------------------------------------------------
// select_next_hop
//   Scans the neighbour table held in shared word memory (qValue[i] and
//   neighbourID[i]), picks the neighbour with the smallest qValue (unsigned,
//   ties keep the lower index) and writes the chosen ID and qValue back.
//
//   Ports:
//     clock   single clock, all state on the rising edge
//     rst     synchronous reset, active-high; aborts a scan immediately
//     bus     select_next_hop_if.master: start/done handshake plus the memory
//             bus (address, wr_en, data_out registered; data_in from memory)
//
//   Optional feature macro: NEXTHOP_IGNORE_ZERO_EN
//     defined   - qValue 0 marks an unreachable neighbour, never selected;
//                 an all-zero table yields FFFF/FFFF results.
//     undefined - qValue 0 is an ordinary (best possible) value.
// -----------------------------------------------------------------------------
module select_next_hop #(
    parameter int unsigned           WORD_WIDTH    = 16,
    parameter logic [WORD_WIDTH-1:0] NCNT_ADDR     = 16'h068A,
    parameter logic [WORD_WIDTH-1:0] QVAL_BASE     = 16'h01C8,
    parameter logic [WORD_WIDTH-1:0] NID_BASE      = 16'h01A8,
    parameter logic [WORD_WIDTH-1:0] BEST_ID_ADDR  = 16'h06A0,
    parameter logic [WORD_WIDTH-1:0] BEST_Q_ADDR   = 16'h06A2,
    parameter int unsigned           MAX_NEIGHBORS = 8
) (
    input  logic              clock,
    input  logic              rst,
    select_next_hop_if.master bus
);

    // Index width holds 0..MAX_NEIGHBORS inclusive (the post-increment value).
    localparam int unsigned           IW    = $clog2(MAX_NEIGHBORS + 1);
    localparam logic [WORD_WIDTH-1:0] MAX_W = WORD_WIDTH'(MAX_NEIGHBORS);
    localparam logic [IW-1:0]         MAX_I = IW'(MAX_NEIGHBORS);
    localparam logic [WORD_WIDTH-1:0] NONE  = {WORD_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_NCNT = 3'd1,
        S_RD_Q    = 3'd2,
        S_RD_ID   = 3'd3,
        S_WR_ID   = 3'd4,
        S_WR_Q    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t                state_r;
    logic [WORD_WIDTH-1:0] address_r;
    logic                  wr_en_r;
    logic [WORD_WIDTH-1:0] data_out_r;
    logic                  done_r;
    logic [IW-1:0]         idx_r;
    logic [IW-1:0]         cnt_r;
    logic [WORD_WIDTH-1:0] q_r;
    logic [WORD_WIDTH-1:0] best_id_r;
    logic [WORD_WIDTH-1:0] best_q_r;
    logic                  have_r;     // a candidate has already been accepted

    logic [IW-1:0]         cnt_clamp_s;
    logic [IW-1:0]         idx_next_s;
    logic                  take_s;
    logic [WORD_WIDTH-1:0] best_id_nxt_s;
    logic [WORD_WIDTH-1:0] best_q_nxt_s;

    // Table entries are word pairs apart; wraps modulo 2^WORD_WIDTH.
    function automatic logic [WORD_WIDTH-1:0] entry_addr(
        input logic [WORD_WIDTH-1:0] base,
        input logic [IW-1:0]         idx
    );
        return base + {{(WORD_WIDTH-IW-1){1'b0}}, idx, 1'b0};
    endfunction

    // Candidate acceptance: first eligible entry always wins, later ones only
    // on a strictly smaller qValue so ties keep the lower index.
    function automatic logic take_candidate(
        input logic                  first,
        input logic [WORD_WIDTH-1:0] q,
        input logic [WORD_WIDTH-1:0] best
    );
`ifdef NEXTHOP_IGNORE_ZERO_EN
        return (q != {WORD_WIDTH{1'b0}}) && (first || (q < best));
`else
        return first || (q < best);
`endif
    endfunction

    // Count clamp, index increment and running-minimum update.
    always_comb begin
        cnt_clamp_s   = (bus.data_in > MAX_W) ? MAX_I : bus.data_in[IW-1:0];
        idx_next_s    = idx_r + {{(IW-1){1'b0}}, 1'b1};
        take_s        = take_candidate(!have_r, q_r, best_q_r);
        best_id_nxt_s = take_s ? bus.data_in : best_id_r;
        best_q_nxt_s  = take_s ? q_r : best_q_r;
    end

    // Scan controller; every bus output is a register of this block.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r    <= S_IDLE;
            address_r  <= NCNT_ADDR;
            wr_en_r    <= 1'b0;
            data_out_r <= {WORD_WIDTH{1'b0}};
            done_r     <= 1'b0;
            idx_r      <= {IW{1'b0}};
            cnt_r      <= {IW{1'b0}};
            q_r        <= {WORD_WIDTH{1'b0}};
            best_id_r  <= NONE;
            best_q_r   <= NONE;
            have_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        done_r    <= 1'b0;
                        address_r <= NCNT_ADDR;
                        idx_r     <= {IW{1'b0}};
                        best_id_r <= NONE;
                        best_q_r  <= NONE;
                        have_r    <= 1'b0;
                        state_r   <= S_RD_NCNT;
                    end
                end
                S_RD_NCNT: begin
                    cnt_r <= cnt_clamp_s;
                    if (cnt_clamp_s == {IW{1'b0}}) begin
                        // Empty table: report the FFFF/FFFF sentinels directly.
                        address_r  <= BEST_ID_ADDR;
                        data_out_r <= best_id_r;
                        wr_en_r    <= 1'b1;
                        state_r    <= S_WR_ID;
                    end else begin
                        address_r <= QVAL_BASE;
                        state_r   <= S_RD_Q;
                    end
                end
                S_RD_Q: begin
                    q_r       <= bus.data_in;
                    address_r <= entry_addr(NID_BASE, idx_r);
                    state_r   <= S_RD_ID;
                end
                S_RD_ID: begin
                    best_id_r <= best_id_nxt_s;
                    best_q_r  <= best_q_nxt_s;
                    have_r    <= have_r | take_s;
                    idx_r     <= idx_next_s;
                    if (idx_next_s == cnt_r) begin
                        // Last entry: the ID write uses the just-updated winner.
                        address_r  <= BEST_ID_ADDR;
                        data_out_r <= best_id_nxt_s;
                        wr_en_r    <= 1'b1;
                        state_r    <= S_WR_ID;
                    end else begin
                        address_r <= entry_addr(QVAL_BASE, idx_next_s);
                        state_r   <= S_RD_Q;
                    end
                end
                S_WR_ID: begin
                    address_r  <= BEST_Q_ADDR;
                    data_out_r <= best_q_r;
                    wr_en_r    <= 1'b1;
                    state_r    <= S_WR_Q;
                end
                S_WR_Q: begin
                    wr_en_r <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= S_DONE;
                end
                default: begin
                    wr_en_r <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.address  = address_r;
    assign bus.wr_en    = wr_en_r;
    assign bus.data_out = data_out_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_select_next_hop.sv
// -----------------------------------------------------------------------------
// tb_select_next_hop
//   Self-checking bench for select_next_hop: a word memory model answers the
//   DUT's reads and logs its writes; a reference model computes the expected
//   winner as "minimum qValue over the first min(count,8) entries, lowest index
//   on ties" directly from the table.
// -----------------------------------------------------------------------------
module tb_select_next_hop;

    localparam logic [15:0] NCNT_ADDR    = 16'h068A;
    localparam logic [15:0] QVAL_BASE    = 16'h01C8;
    localparam logic [15:0] NID_BASE     = 16'h01A8;
    localparam logic [15:0] BEST_ID_ADDR = 16'h06A0;
    localparam logic [15:0] BEST_Q_ADDR  = 16'h06A2;

    logic clock = 1'b0;
    logic rst;

    select_next_hop_if bus ();

    select_next_hop dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Memory model: combinational read of the registered address.
    logic [15:0] mem [0:65535];
    assign bus.data_in = mem[bus.address];

    logic [15:0] wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    int          max_qidx;

    // Commit writes and note the highest qValue index the DUT presented.
    always @(posedge clock) begin
        if (bus.wr_en) begin
            mem[bus.address] = bus.data_out;
            wr_addr_q.push_back(bus.address);
            wr_data_q.push_back(bus.data_out);
        end else if (bus.address >= QVAL_BASE && bus.address < QVAL_BASE + 16'd32) begin
            if (int'((bus.address - QVAL_BASE) >> 1) > max_qidx)
                max_qidx = int'((bus.address - QVAL_BASE) >> 1);
        end
    end

    logic [15:0] q_tab  [16];
    logic [15:0] id_tab [16];

    // Observations from the last scan.
    int          obs_lat;
    int          obs_nwr;
    logic [15:0] obs_a0, obs_d0, obs_a1, obs_d1;
    logic        obs_clr;
    logic        obs_wr_at_done;

    function automatic void ref_select(input int ncnt, output logic [15:0] eid,
                                       output logic [15:0] eq, output int eff);
        bit found;
        found = 1'b0;
        eff   = (ncnt > 8) ? 8 : ncnt;
        eid   = 16'hFFFF;
        eq    = 16'hFFFF;
        for (int i = 0; i < eff; i++) begin
`ifdef NEXTHOP_IGNORE_ZERO_EN
            if (q_tab[i] == 16'd0) continue;
`endif
            if (!found || q_tab[i] < eq) begin
                eid   = id_tab[i];
                eq    = q_tab[i];
                found = 1'b1;
            end
        end
    endfunction

    task automatic load_mem(input int ncnt);
        for (int i = 0; i < 16; i++) begin
            mem[QVAL_BASE + 16'(2 * i)] = q_tab[i];
            mem[NID_BASE + 16'(2 * i)]  = id_tab[i];
        end
        mem[NCNT_ADDR] = 16'(ncnt);
    endtask

    // Runs one scan; obs_lat counts rising edges from the start edge through
    // the edge that raises done, inclusive (-1 on timeout).
    task automatic do_scan(input int ncnt, input bit hold_start);
        load_mem(ncnt);
        @(negedge clock);
        wr_addr_q.delete();
        wr_data_q.delete();
        max_qidx  = -1;
        bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        obs_clr = ~bus.done;
        if (!hold_start) bus.start = 1'b0;
        obs_lat        = -1;
        obs_wr_at_done = 1'b1;
        for (int e = 2; e < 200; e++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus.done) begin
                obs_lat        = e;
                obs_wr_at_done = bus.wr_en;
                break;
            end
        end
        bus.start = 1'b0;
        obs_nwr = wr_addr_q.size();
        obs_a0  = (obs_nwr > 0) ? wr_addr_q[0] : 16'h0000;
        obs_d0  = (obs_nwr > 0) ? wr_data_q[0] : 16'h0000;
        obs_a1  = (obs_nwr > 1) ? wr_addr_q[1] : 16'h0000;
        obs_d1  = (obs_nwr > 1) ? wr_data_q[1] : 16'h0000;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        vectors++;
        if ({bus.address, bus.wr_en, bus.data_out, bus.done} !== {NCNT_ADDR, 1'b0, 16'h0000, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: addr=%h wr_en=%b data_out=%h done=%b, want %h 0 0000 0",
                     bus.address, bus.wr_en, bus.data_out, bus.done, NCNT_ADDR);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int          ncnt, lat, mq;
        logic [15:0] eid, eq;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 16; i++) begin
                q_tab[i]  = 16'd100;
                id_tab[i] = 16'(100 + i);
            end
            case (k)
                0: begin
                    ncnt = 3; q_tab[0] = 16'd5; q_tab[1] = 16'd2; q_tab[2] = 16'd7;
                    id_tab[0] = 16'd11; id_tab[1] = 16'd22; id_tab[2] = 16'd33;
                    eid = 16'd22; eq = 16'd2; lat = 10; mq = 2;
                end
                1: begin
                    ncnt = 4; q_tab[0] = 16'd4; q_tab[1] = 16'd4; q_tab[2] = 16'd9; q_tab[3] = 16'd4;
                    id_tab[0] = 16'd1; id_tab[1] = 16'd2; id_tab[2] = 16'd3; id_tab[3] = 16'd4;
                    eid = 16'd1; eq = 16'd4; lat = 12; mq = 3;
                end
                2: begin
                    ncnt = 0; eid = 16'hFFFF; eq = 16'hFFFF; lat = 4; mq = -1;
                end
                3: begin
                    ncnt = 12; q_tab[5] = 16'd50; q_tab[9] = 16'd1;
                    eid = 16'd105; eq = 16'd50; lat = 20; mq = 7;
                end
                default: begin
                    ncnt = 2; q_tab[0] = 16'd0; q_tab[1] = 16'd3;
                    id_tab[0] = 16'd7; id_tab[1] = 16'd8; lat = 8; mq = 1;
`ifdef NEXTHOP_IGNORE_ZERO_EN
                    eid = 16'd8; eq = 16'd3;
`else
                    eid = 16'd7; eq = 16'd0;
`endif
                end
            endcase
            do_scan(ncnt, 1'b0);
            vectors++;
            if ({obs_nwr, obs_a0, obs_d0, obs_a1, obs_d1} !== {32'sd2, BEST_ID_ADDR, eid, BEST_Q_ADDR, eq}) begin
                miscompares++;
                $display("FAIL directed%0d writes: got n=%0d %h<=%h %h<=%h, want 2 %h<=%h %h<=%h",
                         k, obs_nwr, obs_a0, obs_d0, obs_a1, obs_d1, BEST_ID_ADDR, eid, BEST_Q_ADDR, eq);
            end
            vectors++;
            if ({obs_lat, max_qidx, obs_clr, obs_wr_at_done} !== {lat, mq, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL directed%0d timing: got lat=%0d maxq=%0d clr=%b wr_en=%b, want %0d %0d 1 0",
                         k, obs_lat, max_qidx, obs_clr, obs_wr_at_done, lat, mq);
            end
        end
    endtask

    task automatic test_random();
        int          ncnt, eff;
        bit          hold;
        logic [15:0] eid, eq;
        for (int n = 0; n < 40; n++) begin
            ncnt = int'($urandom_range(0, 12));
            hold = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 16; i++) begin
                q_tab[i]  = (n % 2 == 0) ? 16'($urandom_range(0, 6)) : 16'($urandom);
                id_tab[i] = 16'($urandom);
            end
            ref_select(ncnt, eid, eq, eff);
            do_scan(ncnt, hold);
            vectors++;
            if ({obs_nwr, obs_a0, obs_d0, obs_a1, obs_d1} !== {32'sd2, BEST_ID_ADDR, eid, BEST_Q_ADDR, eq}) begin
                miscompares++;
                $display("FAIL random%0d writes (cnt=%0d): got n=%0d %h<=%h %h<=%h, want 2 %h<=%h %h<=%h",
                         n, ncnt, obs_nwr, obs_a0, obs_d0, obs_a1, obs_d1, BEST_ID_ADDR, eid, BEST_Q_ADDR, eq);
            end
            vectors++;
            if ({obs_lat, max_qidx, obs_clr} !== {2 + 2 * eff + 2, eff - 1, 1'b1}) begin
                miscompares++;
                $display("FAIL random%0d timing (cnt=%0d hold=%0b): got lat=%0d maxq=%0d clr=%b, want %0d %0d 1",
                         n, ncnt, hold, obs_lat, max_qidx, obs_clr, 2 + 2 * eff + 2, eff - 1);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        bit          hit;
        logic [15:0] eid, eq;
        int          eff;
        for (int i = 0; i < 16; i++) begin
            q_tab[i]  = 16'(20 - i);
            id_tab[i] = 16'(200 + i);
        end
        load_mem(3);
        @(negedge clock);
        wr_addr_q.delete();
        wr_data_q.delete();
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        hit = 1'b0;
        // Wait for the ID read of entry 1 (address NID_BASE+2 means RD_ID).
        for (int c = 0; c < 50; c++) begin
            if (bus.address == NID_BASE + 16'd2) begin
                hit = 1'b1;
                break;
            end
            @(negedge clock);
        end
        rst = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rst = 1'b0;
        vectors++;
        if ({hit, bus.wr_en, bus.done, bus.address, wr_addr_q.size()} !== {1'b1, 1'b0, 1'b0, NCNT_ADDR, 32'sd0}) begin
            miscompares++;
            $display("FAIL reset_mid: got hit=%b wr_en=%b done=%b addr=%h writes=%0d, want 1 0 0 %h 0",
                     hit, bus.wr_en, bus.done, bus.address, wr_addr_q.size(), NCNT_ADDR);
        end
        repeat (3) @(negedge clock);
        vectors++;
        if ({bus.wr_en, bus.done, wr_addr_q.size()} !== {1'b0, 1'b0, 32'sd0}) begin
            miscompares++;
            $display("FAIL reset_mid idle: got wr_en=%b done=%b writes=%0d, want 0 0 0",
                     bus.wr_en, bus.done, wr_addr_q.size());
        end
        ref_select(3, eid, eq, eff);
        do_scan(3, 1'b0);
        vectors++;
        if ({obs_nwr, obs_a0, obs_d0, obs_a1, obs_d1, obs_lat} !==
            {32'sd2, BEST_ID_ADDR, eid, BEST_Q_ADDR, eq, 2 + 2 * eff + 2}) begin
            miscompares++;
            $display("FAIL reset_mid rescan: got n=%0d %h<=%h %h<=%h lat=%0d, want 2 %h<=%h %h<=%h %0d",
                     obs_nwr, obs_a0, obs_d0, obs_a1, obs_d1, obs_lat,
                     BEST_ID_ADDR, eid, BEST_Q_ADDR, eq, 2 + 2 * eff + 2);
        end
    endtask

    task automatic test_done_hold();
        // done must stay high in DONE without a new start.
        repeat (5) @(negedge clock);
        vectors++;
        if ({bus.done, bus.wr_en} !== {1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL done_hold: got done=%b wr_en=%b, want 1 0", bus.done, bus.wr_en);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        test_reset();
        test_directed();
        test_done_hold();
        test_random();
        test_reset_mid_scan();
        test_done_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
